// File: rtl/load_data_packer_if.sv
// Handshake bundle for the vector load data packer: command, memory response and
// register-file write channels.
interface load_data_packer_if;
  logic        lp_start_i;
  logic [4:0]  vl_i;
  logic [1:0]  vsew_i;
  logic        bcast_i;
  logic        lp_ready_o;
  logic        lp_done_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_rready_o;
  logic        vr_wr_o;
  logic [4:0]  vr_waddr_o;
  logic [31:0] vr_wdata_o;
  logic [3:0]  vr_wbe_o;
  logic        vr_wready_i;

  modport slave (
    input  lp_start_i, vl_i, vsew_i, bcast_i, mem_rvalid_i, mem_rdata_i, mem_be_i, vr_wready_i,
    output lp_ready_o, lp_done_o, mem_rready_o, vr_wr_o, vr_waddr_o, vr_wdata_o, vr_wbe_o
  );

  modport master (
    output lp_start_i, vl_i, vsew_i, bcast_i, mem_rvalid_i, mem_rdata_i, mem_be_i, vr_wready_i,
    input  lp_ready_o, lp_done_o, mem_rready_o, vr_wr_o, vr_waddr_o, vr_wdata_o, vr_wbe_o
  );
endinterface

// File: rtl/load_data_packer.sv
// Packs enabled byte lanes of memory read responses into a dense byte stream and writes it
// to the vector register file as 32-bit words; stride-0 loads replicate one element.
module load_data_packer (
  input logic               clk_i,
  input logic               rst_i,
  load_data_packer_if.slave lp_io
);

  typedef enum logic [2:0] {StIdle, StCollect, StBcastWait, StBcastWr, StDone} state_e;

  state_e      state_q;
  logic [63:0] buf_q;
  logic [3:0]  cnt_q;
  logic [6:0]  rem_q;
  logic [4:0]  waddr_q;
  logic [1:0]  vsew_q;
  logic [31:0] elem_q;

  logic        wr, rready, wfire, afire;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [3:0]  pop, cnt_n;
  logic [6:0]  rem_n;
  logic [63:0] buf_n;
  logic [31:0] elem_n, elem_rep;

  always_comb begin
    unique case (vsew_q)
      2'd0:    elem_rep = {4{elem_q[7:0]}};
      2'd1:    elem_rep = {2{elem_q[15:0]}};
      default: elem_rep = elem_q;
    endcase
  end

  always_comb begin
    wr     = 1'b0;
    rready = 1'b0;
    wdata  = '0;
    wbe    = '0;
    unique case (state_q)
      StCollect: begin
        wr     = (cnt_q >= 4'd4) || (rem_q == 7'd0 && cnt_q != 4'd0);
        rready = (cnt_q <= 4'd3) || (wr && lp_io.vr_wready_i);
        wdata  = buf_q[31:0];
        wbe    = (cnt_q >= 4'd4) ? 4'hf : ((4'd1 << cnt_q[1:0]) - 4'd1);
      end
      StBcastWait: rready = 1'b1;
      StBcastWr: begin
        wr    = 1'b1;
        wdata = elem_rep;
        wbe   = (rem_q >= 7'd4) ? 4'hf : ((4'd1 << rem_q[1:0]) - 4'd1);
      end
      default: ;
    endcase
  end

  assign wfire = wr && lp_io.vr_wready_i;
  assign afire = rready && lp_io.mem_rvalid_i;

  // Pop the written word first, then append incoming lanes behind the survivors.
  always_comb begin
    pop   = '0;
    if (wfire) pop = (cnt_q >= 4'd4) ? 4'd4 : cnt_q;
    cnt_n = cnt_q - pop;
    buf_n = buf_q >> {pop, 3'b000};
    rem_n = rem_q;
    if (afire) begin
      for (int l = 0; l < 4; l++) begin
        if (lp_io.mem_be_i[l] && rem_n != 7'd0) begin
          buf_n[{cnt_n[2:0], 3'b000} +: 8] = lp_io.mem_rdata_i[8*l +: 8];
          cnt_n = cnt_n + 4'd1;
          rem_n = rem_n - 7'd1;
        end
      end
    end
  end

  // Broadcast element comes from the lowest enabled lane of its width.
  always_comb begin
    elem_n = lp_io.mem_rdata_i;
    unique case (vsew_q)
      2'd0: begin
        elem_n = {24'd0, lp_io.mem_rdata_i[31:24]};
        for (int l = 3; l >= 0; l--) begin
          if (lp_io.mem_be_i[l]) elem_n = {24'd0, lp_io.mem_rdata_i[8*l +: 8]};
        end
      end
      2'd1: elem_n = lp_io.mem_be_i[0] ? {16'd0, lp_io.mem_rdata_i[15:0]}
                                       : {16'd0, lp_io.mem_rdata_i[31:16]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      vsew_q  <= '0;
      elem_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lp_io.lp_start_i) begin
            vsew_q  <= lp_io.vsew_i;
            rem_q   <= {2'b00, lp_io.vl_i} << lp_io.vsew_i;
            waddr_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            if (lp_io.vl_i == 5'd0)  state_q <= StDone;
            else if (lp_io.bcast_i) state_q <= StBcastWait;
            else                    state_q <= StCollect;
          end
        end
        StCollect: begin
          buf_q <= buf_n;
          cnt_q <= cnt_n;
          rem_q <= rem_n;
          if (wfire) waddr_q <= waddr_q + 5'd1;
          if (rem_n == 7'd0 && cnt_n == 4'd0) state_q <= StDone;
        end
        StBcastWait: begin
          if (afire) begin
            elem_q  <= elem_n;
            state_q <= StBcastWr;
          end
        end
        StBcastWr: begin
          if (wfire) begin
            waddr_q <= waddr_q + 5'd1;
            rem_q   <= (rem_q >= 7'd4) ? rem_q - 7'd4 : 7'd0;
            if (rem_q <= 7'd4) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lp_io.mem_rready_o = rready;
  assign lp_io.vr_wr_o      = wr;
  assign lp_io.vr_wdata_o   = wdata;
  assign lp_io.vr_wbe_o     = wbe;
  assign lp_io.vr_waddr_o   = waddr_q;
  assign lp_io.lp_ready_o   = (state_q == StIdle);
  assign lp_io.lp_done_o    = (state_q == StDone);

endmodule
